lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit between the pipeline memory stage and the data memory.
- Accepts one byte, halfword or word request at a time and drives the word-addressed data memory port: address, write enable, write data, plus the combinational read data coming back.
- Performs load lane extraction with sign or zero extension.
- Performs sub-word stores by read-modify-write, because the data memory writes whole words only.
- Flags misaligned and out-of-range accesses, and returns one response per request over a valid/ready handshake.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the data memory. Word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load result. Ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result. 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size.
- dmem_we  out  1  memory write enable.
- dmem_a  out  32  memory byte address, always word-aligned.
- dmem_wd  out  32  memory write data.
- dmem_rd  in  32  memory read data, combinational from dmem_a.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_a=0, dmem_wd=0.
  - All request registers are cleared.
- Lanes are little-endian: byte n = bits [8n+7:8n]; halfword at addr[1]=1 occupies [31:16].
- All memory-side outputs are decoded from registered state only, never from req_* inputs.
- States:
  - IDLE:
    - req_ready=1. On req_valid, latch we/size/signed/addr/wdata.
    - Error if size==11, or byte offset not aligned to size (half needs addr[0]=0; word needs addr[1:0]=0), or addr[31:2] >= MEM_WORDS. Error goes to RESP with err=1.
    - Otherwise: load goes to LOAD; word store goes to WRITE; byte/half store goes to RMW_RD.
  - LOAD: dmem_a={addr[31:2],2'b00}. Extract lane from dmem_rd, extend per signed, register into resp_rdata. Go to RESP.
  - RMW_RD: dmem_a as in LOAD. Register merge of dmem_rd with the low byte/half of wdata into the selected lane(s) as the write word. Go to WRITE.
  - WRITE: dmem_we=1, dmem_a as above, dmem_wd=write word. Memory updates at the edge leaving this state. Go to RESP.
  - RESP:
    - resp_valid=1; resp_rdata and resp_err are held stable while resp_ready=0.
    - On resp_ready=1, go to IDLE; resp_valid drops next cycle.
- req_ready=0 in every state except IDLE. There is no request overlap.
- dmem_we is 1 only in WRITE. Errors never write memory.
- Latency from the accept edge T to first resp_valid cycle:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Back-to-back throughput: at most one request every 3 cycles (load or word store) with resp_ready held at 1.
- Reset mid-operation: asserting reset_n=0 in any state returns to IDLE immediately and drops dmem_we asynchronously. A store whose WRITE edge has not occurred is lost. No response is produced for the aborted request.
- Simultaneous events: req_valid while not IDLE is ignored and not latched; the requester must hold it.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - state enum IDLE, LOAD, RMW_RD, WRITE, RESP.
  - function for the alignment-error check.
- Sub-module lsu_lane_align (combinational), with two functions:
  - Given word, byte offset, size and signed, returns the extended load value.
  - Given old word, store data, offset and size, returns the merged word.
- The top holds the FSM and registers only.

Test Plan:
- Preload word index 4 (addr 0x10) = 0x8899AABB.
  - Signed byte load at 0x11 -> resp_rdata=0xFFFFFFAA, resp_valid at T+2, dmem_we never 1.
  - Unsigned half load at 0x12 -> resp_rdata=0x00008899.
- Store byte 0x5C at 0x12 (same preload) -> dmem_we=1 only at T+2 with dmem_a=0x10, dmem_wd=0x885CAABB. A subsequent word load at 0x10 returns 0x885CAABB.
- Half load at 0x13, then word load at 0x100 (index 64) -> each gives resp_err=1, resp_rdata=0 at T+1, no dmem_we.
- Word store 0xDEADBEEF at 0x0C, resp_ready held 0 for 3 cycles -> resp_valid/resp_err=0 stable and req_ready=0 throughout. Completes on resp_ready=1. A new req_valid during the hold is not accepted.
- Sub-word store at 0x10 with reset_n pulsed low during RMW_RD -> dmem_we never 1, memory still 0x8899AABB, outputs at reset values, next request accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the alignment check for the load/store unit.
// Sizes are byte/half/word; the fourth encoding is illegal and rejected at accept.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extraction with sign/zero extension, and store merge.
// Purely combinational; the caller registers both results.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = old;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    m[7:0]   = wdata[7:0];
          2'd1:    m[15:8]  = wdata[7:0];
          2'd2:    m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) m[31:16] = wdata[15:0];
        else        m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign o_load  = load_extend(i_word, i_off, i_size, i_signed);
  assign o_merge = store_merge(i_word, i_wdata, i_off, i_size);

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit FSM: one request at a time, sub-word stores via read-modify-write.
// Memory port is decoded from registered state only; response held until resp_ready.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_err = (req_size == SZ_ILL) || misaligned(req_size, req_addr[1:0]) ||
                 (req_addr[31:2] >= 30'(MEM_WORDS));

  lsu_lane_align u_lane (
    .i_word   (dmem_rd),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // r_wdata doubles as the write word once RMW_RD has merged into it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= RESP;
            end else if (!req_we) begin
              r_state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              r_state <= WRITE;
            end else begin
              r_state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          r_resp_rdata <= r_we ? 32'd0 : w_load;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RMW_RD: begin
          r_wdata <= w_merge;
          r_state <= WRITE;
        end
        WRITE: begin
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign dmem_we    = (r_state == WRITE);
  assign dmem_a     = {r_addr[31:2], 2'b00};
  assign dmem_wd    = (r_state == WRITE) ? r_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed requests push expected responses and
// expected memory writes; a negedge monitor pops and compares them as they appear.
module tb_lsu_mem_stage;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  always #5 clk = ~clk;

  lsu_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_we    (dmem_we),
    .dmem_a     (dmem_a),
    .dmem_wd    (dmem_wd),
    .dmem_rd    (dmem_rd)
  );

  logic [31:0] mem [0:MEM_WORDS-1];
  assign dmem_rd = (dmem_a[31:2] < MEM_WORDS) ? mem[dmem_a[7:2]] : 32'd0;
  always @(posedge clk) if (dmem_we && dmem_a[31:2] < MEM_WORDS) mem[dmem_a[7:2]] <= dmem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {string name; logic [31:0] rdata; logic err; int acc; int lat;} resp_t;
  typedef struct {string name; logic [31:0] a; logic [31:0] wd; int acc; int lat;} wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  resp_t e_r;
  wr_t   e_w;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic resp_t R(input string n, input logic [31:0] rd, input logic er, input int l);
    resp_t r;
    r.name = n; r.rdata = rd; r.err = er; r.acc = 0; r.lat = l;
    return r;
  endfunction

  function automatic wr_t W(input string n, input logic [31:0] a, input logic [31:0] wd, input int l);
    wr_t w;
    w.name = n; w.a = a; w.wd = wd; w.acc = 0; w.lat = l;
    return w;
  endfunction

  // Monitor: response scoreboard, hold stability and memory-write scoreboard.
  logic        seen = 1'b0;
  int          first_cyc = 0;
  logic [31:0] held_rd;
  logic        held_err;
  always @(negedge clk) begin
    if (!reset_n) seen = 1'b0;
    if (reset_n && resp_valid) begin
      if (!seen) begin
        seen = 1'b1; first_cyc = cyc; held_rd = resp_rdata; held_err = resp_err;
      end else begin
        chk("hold_rdata", resp_rdata, held_rd);
        chk("hold_err", {31'd0, resp_err}, {31'd0, held_err});
      end
      if (resp_ready) begin
        seen = 1'b0;
        if (rq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_resp: got rdata %h err %b, expected none", resp_rdata, resp_err);
        end else begin
          e_r = rq.pop_front();
          chk({e_r.name, "_rdata"}, resp_rdata, e_r.rdata);
          chk({e_r.name, "_err"}, {31'd0, resp_err}, {31'd0, e_r.err});
          chk({e_r.name, "_lat"}, first_cyc - e_r.acc, e_r.lat);
        end
      end
    end
    if (reset_n && dmem_we) begin
      if (wq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_dmem_we: got a %h wd %h, expected no write", dmem_a, dmem_wd);
      end else begin
        e_w = wq.pop_front();
        chk({e_w.name, "_a"}, dmem_a, e_w.a);
        chk({e_w.name, "_wd"}, dmem_wd, e_w.wd);
        chk({e_w.name, "_lat"}, cyc - e_w.acc, e_w.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit has_r, input resp_t r, input bit has_w, input wr_t w,
                       output int acc);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    acc = cyc;
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL req_ready_timeout: got req_ready 0 for 50 cycles, expected 1");
    end else begin
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      r.acc = acc; w.acc = acc;
      if (has_r) rq.push_back(r);
      if (has_w) wq.push_back(w);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 50) begin @(negedge clk); t++; end
    chk("drain_resp_q", rq.size(), 0);
    chk("drain_wr_q", wq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({p, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({p, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({p, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({p, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
    chk({p, "_dmem_a"}, dmem_a, 32'd0);
    chk({p, "_dmem_wd"}, dmem_wd, 32'd0);
  endtask

  wr_t   nw;
  resp_t nr;
  int    a0, a1, a2, ax;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
    mem[4]  = 32'h8899AABB;
    mem[5]  = 32'h11223344;
    mem[63] = 32'hCAFEF00D;
    nw = W("none", 32'd0, 32'd0, 0);
    nr = R("none", 32'd0, 1'b0, 0);

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, 2'b00, 1, 32'h11, 32'h0, 1, R("lb_s_11", 32'hFFFFFFAA, 0, 2), 0, nw, ax);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 1, R("lhu_12", 32'h00008899, 0, 2), 0, nw, ax);
    issue(1, 2'b00, 0, 32'h12, 32'h0000005C, 1, R("sb_12", 32'h0, 0, 3),
          1, W("sb_12_wr", 32'h10, 32'h885CAABB, 2), ax);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1, R("lw_10", 32'h885CAABB, 0, 2), 0, nw, ax);
    issue(0, 2'b01, 1, 32'h10, 32'h0, 1, R("lh_s_10", 32'hFFFFAABB, 0, 2), 0, nw, ax);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 1, R("lbu_13", 32'h00000088, 0, 2), 0, nw, ax);
    issue(0, 2'b01, 0, 32'h13, 32'h0, 1, R("lh_mis_13", 32'h0, 1, 1), 0, nw, ax);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 1, R("lw_oor_100", 32'h0, 1, 1), 0, nw, ax);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 1, R("ill_size", 32'h0, 1, 1), 0, nw, ax);
    issue(1, 2'b10, 0, 32'h0E, 32'h12345678, 1, R("sw_mis_0e", 32'h0, 1, 1), 0, nw, ax);
    issue(1, 2'b01, 0, 32'h16, 32'hFFFF1234, 1, R("sh_16", 32'h0, 0, 3),
          1, W("sh_16_wr", 32'h14, 32'h12343344, 2), ax);
    issue(0, 2'b00, 1, 32'h14, 32'h0, 1, R("lb_s_14", 32'h00000044, 0, 2), 0, nw, ax);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 1, R("lw_14", 32'h12343344, 0, 2), 0, nw, ax);
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 1, R("lw_last_fc", 32'hCAFEF00D, 0, 2), 0, nw, ax);

    issue(0, 2'b10, 0, 32'h10, 32'h0, 1, R("tp0", 32'h885CAABB, 0, 2), 0, nw, a0);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 1, R("tp1", 32'h12343344, 0, 2), 0, nw, a1);
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 1, R("tp2", 32'hCAFEF00D, 0, 2), 0, nw, a2);
    chk("tp_gap01", a1 - a0, 3);
    chk("tp_gap12", a2 - a1, 3);
    drain();

    resp_ready = 1'b0;
    issue(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 1, R("sw_0c_hold", 32'h0, 0, 2),
          1, W("sw_0c_wr", 32'h0C, 32'hDEADBEEF, 1), ax);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_resp_err", {31'd0, resp_err}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    drain();
    issue(0, 2'b10, 0, 32'h0C, 32'h0, 1, R("lw_0c", 32'hDEADBEEF, 0, 2), 0, nw, ax);
    drain();

    mem[4] = 32'h8899AABB;
    issue(1, 2'b00, 0, 32'h10, 32'h00000077, 0, nr, 0, nw, ax);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_mem4", mem[4], 32'h8899AABB);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1, R("lw_after_rst", 32'h8899AABB, 0, 2), 0, nw, ax);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
